// File: rtl/inst_encoder_loader.sv
// RV32I field-to-word encoder that queues requests and streams them into imem.
// Optional rolling checksum of written words is enabled by defining ENC_CHECKSUM_EN.
module inst_encoder_loader #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [1:0]        in_rop,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              err,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] word_count,
   output logic              done,
   output logic [31:0]       checksum
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   localparam logic [1:0] KIND_R   = 2'd0;
   localparam logic [1:0] KIND_LW  = 2'd1;
   localparam logic [1:0] KIND_SW  = 2'd2;
   localparam logic [1:0] KIND_BEQ = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      LOADING,
      DONE
   } state_t;

   state_t            state;
   logic              last_seen;
   logic [31:0]       fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_count;
   logic [ADDR_W-1:0] next_addr;

   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              req_legal;
   logic              push;
   logic              pop;
   logic              session_start;
   logic [31:0]       req_word;

   function automatic logic [31:0] encode(
      input logic [1:0]  kind,
      input logic [1:0]  rop,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [12:0] imm
   );
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] word;
      funct3 = 3'b000;
      funct7 = 7'b0000000;
      case (rop)
         2'd1:    funct7 = 7'b0100000;
         2'd2:    funct3 = 3'b111;
         2'd3:    funct3 = 3'b110;
         default: funct3 = 3'b000;
      endcase
      case (kind)
         KIND_LW:  word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
         KIND_SW:  word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         KIND_BEQ: word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
         default:  word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      endcase
      return word;
   endfunction

   // Illegal requests are still handshaken so the producer never stalls on them.
   always_comb begin
      fifo_full     = (fifo_count == FULL_COUNT);
      fifo_empty    = (fifo_count == '0);
      session_start = (state != LOADING) && start;
      accept        = in_valid && in_ready;
      req_word      = encode(in_kind, in_rop, in_rd, in_rs1, in_rs2, in_imm);
      case (in_kind)
         KIND_LW, KIND_SW: req_legal = (in_imm[12] == in_imm[11]);
         KIND_BEQ:         req_legal = !in_imm[0];
         default:          req_legal = 1'b1;
      endcase
      push = accept && req_legal;
      pop  = (state == LOADING) && !fifo_empty;
   end

   assign in_ready = (state == LOADING) && !fifo_full && !last_seen;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= req_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_seen  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         next_addr  <= BASE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE;
         imem_wdata <= '0;
         err        <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
         done       <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         err     <= 1'b0;
         if (session_start) begin
            state      <= LOADING;
            last_seen  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            next_addr  <= BASE;
            imem_addr  <= BASE;
            word_count <= '0;
            err_count  <= '0;
            done       <= 1'b0;
         end else if (state == LOADING) begin
            if (accept) begin
               if (in_last) begin
                  last_seen <= 1'b1;
               end
               if (!req_legal) begin
                  err <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr     <= rd_ptr + PTR_W'(1);
               imem_we    <= 1'b1;
               imem_addr  <= next_addr;
               imem_wdata <= fifo_mem[rd_ptr];
               next_addr  <= next_addr + ADDR_W'(4);
               word_count <= word_count + ADDR_W'(1);
            end
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
               2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
               default: fifo_count <= fifo_count;
            endcase
            // last_seen blocks further pushes, so an empty FIFO here means everything is written.
            if (last_seen && fifo_empty) begin
               state <= DONE;
               done  <= 1'b1;
            end
         end
      end
   end

`ifdef ENC_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || session_start) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= {checksum[30:0], checksum[31]} ^ fifo_mem[rd_ptr];
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Encodes RV32I instructions (R-type ADD/SUB/AND/OR, LW, SW, BEQ) from field-level requests into 32-bit words and writes them sequentially into instruction memory.
- It is the inverse of the control/decode path and serves as the testbench and boot-time program loader.
- Requests enter over a valid/ready handshake, are buffered in a small FIFO, and are drained to the imem write port one word per cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 10, imem byte-address width.
- BASE_ADDR, 0, byte address loaded on start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a load session
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when valid&&ready
- in_kind  in  2  0=R, 1=LW, 2=SW, 3=BEQ
- in_rop  in  2  R only: 0=ADD, 1=SUB, 2=AND, 3=OR
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  13  signed immediate
- in_last  in  1  marks the final request of the session
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded word
- err  out  1  one-cycle pulse on a rejected request
- err_count  out  8  count of rejected requests; saturates at 255
- word_count  out  ADDR_W  words written this session
- done  out  1  session complete
- checksum  out  32  see Optional Feature

Behaviour:
- Reset: clock is clk; reset rst is synchronous, active-high. All outputs are 0, FIFO is empty, state is IDLE, and imem_addr is BASE_ADDR. rst mid-session aborts immediately; nothing pending is written.
- State IDLE: start moves to LOADING.
- State LOADING: entered with imem_addr=BASE_ADDR, word_count=0, err_count=0 and last_seen=0.
  - in_ready = (state==LOADING) && !fifo_full && !last_seen. Readiness is not granted on a same-cycle pop when full.
  - When the accepted in_last has been written and the FIFO is empty, move to DONE.
- State DONE: done=1. start returns to LOADING (counters cleared). start is ignored while in LOADING.
- Encoding (opcodes):
  - R: funct7|rs2|rs1|funct3|rd|0110011. funct3 is 000 for ADD/SUB, 111 for AND, 110 for OR. funct7 is 0100000 for SUB, otherwise 0.
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - Unused fields in the request are ignored.
- Legality and rejection:
  - LW/SW are legal only if imm[12]==imm[11], i.e. the value fits in 12 signed bits.
  - BEQ is legal only if imm[0]==0.
  - An illegal request is still handshaken (consumed) but not queued. err pulses the next cycle and err_count increments.
  - An illegal in_last request still sets last_seen.
- Timing: a push at edge N makes the word the FIFO head. It is popped the following cycle. imem_we/addr/wdata are registered, so an accepted word appears on imem in cycle N+2 when the FIFO is empty. This is one word per cycle sustained.
- Address and count: after each write imem_addr advances by 4 and wraps modulo 2^ADDR_W. word_count increments with each imem_we.
- imem_we is high for exactly one cycle per word. imem_addr/imem_wdata hold their values between writes.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.

Optional Feature:
- ENC_CHECKSUM_EN defined: checksum is reset to 0 on start and rst. Each written word updates it as {checksum[30:0],checksum[31]} XOR imem_wdata, registered and updated in the same cycle as imem_we.
- Not defined: checksum is tied to 0 and no logic is generated.

Test Plan:
- start; R ADD rd=3 rs1=1 rs2=2 -> imem_wdata=0x002081B3 at addr 0. R SUB with the same fields -> 0x402081B3 at addr 4. word_count=2.
- LW rd=5 rs1=1 imm=8 -> 0x0080A283. SW rs1=2 rs2=5 imm=12 -> 0x00512623. BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3. Addresses are 0, 4, 8.
- LW imm=2048 and BEQ imm=3 -> no imem_we, two err pulses, err_count=2. A following legal request is written at addr 0.
- Hold imem in steady state: stream 6 back-to-back requests with in_last on the 6th -> 6 consecutive imem_we cycles. done rises the cycle after the last write and in_ready stays 0 until the next start.
- Assert rst with 3 words queued -> no further imem_we and all outputs 0. A new start rewrites from BASE_ADDR.
- With ENC_CHECKSUM_EN, write 0x002081B3 then 0x402081B3 -> checksum=0x00410366 ^ 0x402081B3 = 0x406182D5. Without the macro, checksum stays 0.
